// File: rtl/class_decider_pkg.sv
// ---- nn_parameters : shared network dimensions, class id type, decider FSM encoding (rev 1.0) ----
`default_nettype none
package nn_parameters;

  // NN_NUM_CLASSES must match the output size of the final dense layer.
  localparam int NN_NUM_CLASSES = 3;
  localparam int NN_DATA_WIDTH  = 16;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

  localparam int NN_CLASS_ID_W = clog2_min1(NN_NUM_CLASSES);
  typedef logic [NN_CLASS_ID_W-1:0] class_id_t;

  localparam int               STATE_W    = 1;
  localparam logic [STATE_W-1:0] ST_COLLECT = 1'b0;
  localparam logic [STATE_W-1:0] ST_EMIT    = 1'b1;

endpackage
`default_nettype wire

// File: rtl/class_decider_if.sv
// ---- class_decider_if : logit input stream and class decision output bundle (rev 1.0) ----
`default_nettype none
interface class_decider_if
  import nn_parameters::*;
#(
  parameter int DATA_WIDTH  = NN_DATA_WIDTH,
  parameter int NUM_CLASSES = NN_NUM_CLASSES
);
  localparam int ID_W = clog2_min1(NUM_CLASSES);

  logic                         logit_valid;
  logic                         logit_ready;
  logic signed [DATA_WIDTH-1:0] logit_data;
  logic                         logit_last;
  logic                         class_valid;
  logic                         class_ready;
  logic [ID_W-1:0]              class_id;
  logic signed [DATA_WIDTH-1:0] class_score;
  logic                         class_confident;
  logic                         frame_error;

  modport master (
    output logit_valid, logit_data, logit_last, class_ready,
    input  logit_ready, class_valid, class_id, class_score, class_confident, frame_error
  );

  modport slave (
    input  logit_valid, logit_data, logit_last, class_ready,
    output logit_ready, class_valid, class_id, class_score, class_confident, frame_error
  );
endinterface
`default_nettype wire

// File: rtl/class_decider_top2_tracker.sv
// ---- top2_tracker : running max / argmax / second max over one frame (rev 1.0) ----
`default_nettype none
module top2_tracker #(
  parameter int DATA_WIDTH = 16,
  parameter int ID_W       = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_i,
  input  logic                         update_i,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic [ID_W-1:0]              idx_i,
  output logic signed [DATA_WIDTH-1:0] max_o,
  output logic signed [DATA_WIDTH-1:0] second_o,
  output logic [ID_W-1:0]              argmax_o
);
  localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [DATA_WIDTH-1:0] max_q, max_d, second_q, second_d;
  logic [ID_W-1:0]              argmax_q, argmax_d;

  // Strict compares: an equal later value never displaces the earlier index.
  always_comb begin
    max_d    = max_q;
    second_d = second_q;
    argmax_d = argmax_q;
    if (update_i) begin
      if (data_i > max_q) begin
        second_d = max_q;
        max_d    = data_i;
        argmax_d = idx_i;
      end else if (data_i > second_q) begin
        second_d = data_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      max_q    <= MOST_NEG;
      second_q <= MOST_NEG;
      argmax_q <= '0;
    end else begin
      max_q    <= max_d;
      second_q <= second_d;
      argmax_q <= argmax_d;
    end
  end

  // Results include the element arriving this cycle so the last one is decided on time.
  assign max_o    = max_d;
  assign second_o = second_d;
  assign argmax_o = argmax_d;
endmodule
`default_nettype wire

// File: rtl/class_decider.sv
// ---- class_decider : frame argmax with confidence margin and handshaked decision (rev 1.0) ----
// Optional CLASS_DECIDER_SMOOTHING_EN: emit only after HOLD_FRAMES matching confident frames.
`default_nettype none
module class_decider
  import nn_parameters::*;
#(
  parameter int DATA_WIDTH  = NN_DATA_WIDTH,
  parameter int NUM_CLASSES = NN_NUM_CLASSES,
  parameter int MARGIN      = 0,
  parameter int HOLD_FRAMES = 3
) (
  input  logic           clk,
  input  logic           rst,
  class_decider_if.slave bus
);
  localparam int ID_W  = clog2_min1(NUM_CLASSES);
  localparam int IDX_W = clog2_min1(NUM_CLASSES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);
  localparam logic [IDX_W-1:0] OVF_IDX  = IDX_W'(NUM_CLASSES);
  localparam logic signed [DATA_WIDTH:0] MARGIN_EXT = (DATA_WIDTH+1)'(MARGIN);

  generate
    if (HOLD_FRAMES < 1 || MARGIN < 0) begin : g_bad_params
      $error("class_decider: HOLD_FRAMES must be >= 1 and MARGIN >= 0");
    end
  endgenerate

  logic [STATE_W-1:0]           state_q, state_d;
  logic [IDX_W-1:0]             idx_q;
  logic                         xfer, good_last, bad_last, emit, confident;
  logic signed [DATA_WIDTH-1:0] top_val, sec_val;
  logic [ID_W-1:0]              top_idx;
  logic signed [DATA_WIDTH:0]   margin;
  logic [ID_W-1:0]              id_q;
  logic signed [DATA_WIDTH-1:0] score_q;
  logic                         conf_q, err_q;

  assign xfer      = bus.logit_valid && bus.logit_ready;
  assign good_last = xfer && bus.logit_last && (idx_q == LAST_IDX);
  assign bad_last  = xfer && bus.logit_last && (idx_q != LAST_IDX);

  top2_tracker #(
    .DATA_WIDTH(DATA_WIDTH),
    .ID_W      (ID_W)
  ) u_tracker (
    .clk     (clk),
    .rst     (rst),
    .clear_i (xfer && bus.logit_last),
    .update_i(xfer && (idx_q != OVF_IDX)),
    .data_i  (bus.logit_data),
    .idx_i   (idx_q[ID_W-1:0]),
    .max_o   (top_val),
    .second_o(sec_val),
    .argmax_o(top_idx)
  );

  // Index saturates at NUM_CLASSES so oversize frames are remembered until logit_last.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else if (xfer) begin
      if (bus.logit_last)        idx_q <= '0;
      else if (idx_q != OVF_IDX) idx_q <= idx_q + IDX_W'(1);
    end
  end

  // One extra bit keeps MAX - MIN from wrapping.
  assign margin    = {top_val[DATA_WIDTH-1], top_val} - {sec_val[DATA_WIDTH-1], sec_val};
  assign confident = (margin >= MARGIN_EXT);

`ifdef CLASS_DECIDER_SMOOTHING_EN
  localparam int CNT_W = clog2_min1(HOLD_FRAMES + 1);
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_FRAMES);

  logic [CNT_W-1:0] run_q, run_d;
  logic [ID_W-1:0]  prev_q;

  always_comb begin
    run_d = run_q;
    if (!confident)                              run_d = '0;
    else if (run_q == '0 || top_idx != prev_q)   run_d = CNT_W'(1);
    else if (run_q < HOLD_C)                     run_d = run_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= '0;
      prev_q <= '0;
    end else if (good_last) begin
      run_q  <= run_d;
      prev_q <= top_idx;
    end
  end

  assign emit = confident && (run_d >= HOLD_C);
`else
  assign emit = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_COLLECT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: if (good_last && emit) state_d = ST_EMIT;
      ST_EMIT:    if (bus.class_ready)   state_d = ST_COLLECT;
      default:                           state_d = ST_COLLECT;
    endcase
  end

  always_comb begin
    bus.logit_ready = (state_q == ST_COLLECT);
    bus.class_valid = (state_q == ST_EMIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_q    <= '0;
      score_q <= '0;
      conf_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= bad_last;
      if (good_last && emit) begin
        id_q    <= top_idx;
        score_q <= top_val;
        conf_q  <= confident;
      end
    end
  end

  assign bus.class_id        = id_q;
  assign bus.class_score     = score_q;
  assign bus.class_confident = conf_q;
  assign bus.frame_error     = err_q;
endmodule
`default_nettype wire

// File: tb/tb_class_decider.sv
// ---- tb_class_decider : directed + random frames against a frame-level reference model (rev 1.0) ----
`default_nettype none
module tb_class_decider;
  import nn_parameters::*;

  localparam int W    = 16;
  localparam int NC   = 3;
  localparam int HOLD = 3;
  localparam int M0   = 0;
  localparam int M1   = 1;
`ifdef CLASS_DECIDER_SMOOTHING_EN
  localparam bit SMOOTH = 1'b1;
`else
  localparam bit SMOOTH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  class_decider_if #(.DATA_WIDTH(W), .NUM_CLASSES(NC)) bus0 ();
  class_decider_if #(.DATA_WIDTH(W), .NUM_CLASSES(NC)) bus1 ();

  assign bus1.logit_valid = bus0.logit_valid;
  assign bus1.logit_data  = bus0.logit_data;
  assign bus1.logit_last  = bus0.logit_last;
  assign bus1.class_ready = bus0.class_ready;

  class_decider #(.DATA_WIDTH(W), .NUM_CLASSES(NC), .MARGIN(M0), .HOLD_FRAMES(HOLD)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  class_decider #(.DATA_WIDTH(W), .NUM_CLASSES(NC), .MARGIN(M1), .HOLD_FRAMES(HOLD)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: whole frames are judged with plain arithmetic once logit_last arrives.
  bit        pending   = 1'b0;
  bit        exp_err   = 1'b0;
  bit        rst_seen  = 1'b0;
  int        exp_id    = 0;
  int        exp_score = 0;
  bit        exp_conf0 = 1'b0;
  bit        exp_conf1 = 1'b0;
  int        frame_q[$];
  bit        hist_conf[$];
  class_id_t hist_id[$];

  initial begin
    int best, sec, run;
    bit emit, xfer;
    forever begin
      @(negedge clk);
      check("logit_ready", bus0.logit_ready, !pending);
      check("class_valid", bus0.class_valid, pending);
      check("frame_error", bus0.frame_error, exp_err);
      if (pending) begin
        check("class_id", bus0.class_id, exp_id);
        check("class_score", bus0.class_score, exp_score);
        check("class_confident", bus0.class_confident, exp_conf0);
        if (!SMOOTH) check("class_confident_m1", bus1.class_confident, exp_conf1);
      end
      if (rst_seen) begin
        check("rst_class_id", bus0.class_id, 0);
        check("rst_class_score", bus0.class_score, 0);
        check("rst_class_conf", bus0.class_confident, 0);
      end

      xfer = bus0.logit_valid && !pending;
      if (rst) begin
        pending  = 1'b0;
        exp_err  = 1'b0;
        rst_seen = 1'b1;
        frame_q.delete();
        hist_conf.delete();
        hist_id.delete();
      end else begin
        rst_seen = 1'b0;
        exp_err  = 1'b0;
        if (pending && bus0.class_ready) begin
          pending = 1'b0;
        end else if (xfer) begin
          frame_q.push_back(int'(bus0.logit_data));
          if (bus0.logit_last) begin
            if (frame_q.size() != NC) begin
              exp_err = 1'b1;
            end else begin
              best = 0;
              for (int i = 1; i < NC; i++) if (frame_q[i] > frame_q[best]) best = i;
              sec = -(1 << 30);
              for (int i = 0; i < NC; i++) if (i != best && frame_q[i] > sec) sec = frame_q[i];
              exp_conf0 = (frame_q[best] - sec) >= M0;
              exp_conf1 = (frame_q[best] - sec) >= M1;
              emit = 1'b1;
              if (SMOOTH) begin
                hist_conf.push_back(exp_conf0);
                hist_id.push_back(class_id_t'(best));
                run = 0;
                for (int k = hist_id.size() - 1; k >= 0; k--) begin
                  if (hist_conf[k] && hist_id[k] == class_id_t'(best)) run++;
                  else break;
                end
                emit = exp_conf0 && (run >= HOLD);
              end
              if (emit) begin
                pending   = 1'b1;
                exp_id    = best;
                exp_score = frame_q[best];
              end
            end
            frame_q.delete();
          end
        end
      end
    end
  end

  int ready_pct = 100;
  bit gaps      = 1'b0;

  initial begin
    bus0.class_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus0.class_ready = (int'($urandom_range(0, 99)) < ready_pct);
    end
  end

  task automatic send_elem(input int v, input bit last);
    bit accepted;
    if (gaps && $urandom_range(0, 3) == 0) begin
      bus0.logit_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    bus0.logit_valid = 1'b1;
    bus0.logit_data  = v[W-1:0];
    bus0.logit_last  = last;
    accepted = 1'b0;
    for (int n = 0; n < 200 && !accepted; n++) begin
      @(negedge clk);
      accepted = bus0.logit_ready;
      @(posedge clk);
      #1;
    end
    check("send_accepted", accepted, 1);
    bus0.logit_valid = 1'b0;
    bus0.logit_last  = 1'b0;
  endtask

  task automatic frame3(input int a, input int b, input int c);
    send_elem(a, 1'b0);
    send_elem(b, 1'b0);
    send_elem(c, 1'b1);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic int rnd_logit();
    case ($urandom_range(0, 5))
      0:       return -32768;
      1:       return 32767;
      2, 3:    return int'($urandom_range(0, 6)) - 3;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  initial begin
    int len;
    bus0.logit_valid = 1'b0;
    bus0.logit_data  = '0;
    bus0.logit_last  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    frame3(5, -2, 9);
    frame3(7, 7, 1);
    send_elem(1, 1'b0);
    send_elem(2, 1'b1);
    for (int i = 0; i < 3; i++) send_elem(i, 1'b0);
    send_elem(4, 1'b1);
    frame3(0, 3, 1);

    ready_pct = 0;
    fork
      begin
        repeat (12) @(posedge clk);
        ready_pct = 100;
      end
    join_none
    frame3(1, 8, 2);
    frame3(4, 4, 4);

    pulse_reset();
    frame3(0, 5, 1);
    frame3(0, 5, 1);
    repeat (4) frame3(0, 1, 5);

    send_elem(3, 1'b0);
    send_elem(4, 1'b0);
    pulse_reset();
    frame3(-32768, 32767, -32768);
    frame3(32767, -32768, 32767);

    gaps = 1'b1;
    for (int f = 0; f < 300; f++) begin
      case ($urandom_range(0, 2))
        0:       ready_pct = 100;
        1:       ready_pct = 50;
        default: ready_pct = 20;
      endcase
      len = ($urandom_range(0, 9) < 8) ? NC : int'($urandom_range(1, 5));
      for (int i = 0; i < len; i++) send_elem(rnd_logit(), i == len - 1);
    end

    ready_pct = 100;
    repeat (20) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
